// File: rtl/pipe_int_mul_result_buffer.sv
// rtl/pipe_int_mul_result_buffer.sv - result FIFO and in-flight tracker behind the pipelined 32x32 multiplier
module pipe_int_mul_result_buffer #(
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          issue,
   input  logic          commit,
   input  logic [63:0]   longP,
   output logic          issue_allow,
   output logic          res_val,
   input  logic          res_rdy,
   output logic [63:0]   res_data,
   output logic [CW-1:0] occupancy,
   output logic [CW-1:0] inflight,
   output logic          overflow,
   output logic          seq_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          pop;
   logic          push;
   logic [CW:0]   pending;

   assign full    = (occupancy == FULL_CNT);
   assign res_val = (occupancy != '0);
   assign pop     = res_val && res_rdy;
   // a pop frees the slot in the same cycle, so a commit while full still lands
   assign push    = commit && (!full || pop);

   // every slot that is stored or promised to an in-flight op counts against DEPTH
   assign pending     = {1'b0, occupancy} + {1'b0, inflight};
   assign issue_allow = (pending < (CW+1)'(DEPTH));

   assign res_data = res_val ? mem[rd_ptr] : 64'd0;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= longP;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
         inflight  <= '0;
         overflow  <= 1'b0;
         seq_err   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end

         if (push && !pop) begin
            occupancy <= occupancy + CW'(1);
         end else if (pop && !push) begin
            occupancy <= occupancy - CW'(1);
         end

         if (commit && !push) begin
            overflow <= 1'b1;
         end

         // issue and commit together cancel; a commit with nothing outstanding is a sequencing fault
         if (issue && !commit) begin
            if (inflight != FULL_CNT) begin
               inflight <= inflight + CW'(1);
            end
         end else if (commit && !issue) begin
            if (inflight == '0) begin
               seq_err <= 1'b1;
            end else begin
               inflight <= inflight - CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_int_mul_result_buffer.sv
// tb/tb_pipe_int_mul_result_buffer.sv - directed self-checking bench with a product scoreboard
module tb_pipe_int_mul_result_buffer;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          issue;
   logic          commit;
   logic [63:0]   longP;
   logic          issue_allow;
   logic          res_val;
   logic          res_rdy;
   logic [63:0]   res_data;
   logic [CW-1:0] occupancy;
   logic [CW-1:0] inflight;
   logic          overflow;
   logic          seq_err;

   int            tests = 0;
   int            fails = 0;
   logic [63:0]   sb[$];
   int            m_occ = 0;

   pipe_int_mul_result_buffer #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .issue       (issue),
      .commit      (commit),
      .longP       (longP),
      .issue_allow (issue_allow),
      .res_val     (res_val),
      .res_rdy     (res_rdy),
      .res_data    (res_data),
      .occupancy   (occupancy),
      .inflight    (inflight),
      .overflow    (overflow),
      .seq_err     (seq_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs are stable at the falling edge: score pops and pushes there, then advance one cycle.
   task automatic tick();
      logic do_pop;
      logic do_push;
      @(negedge clk);
      do_pop  = res_val && res_rdy;
      do_push = commit && ((m_occ < DEPTH) || do_pop);
      if (do_pop) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL pop_unexpected observed=%0h expected=no_output", res_data);
         end else begin
            chk("pop_data", res_data, sb.pop_front());
         end
      end
      if (!reset) begin
         sb.delete();
         m_occ = 0;
      end else begin
         if (do_push) sb.push_back(longP);
         m_occ = m_occ + int'(do_push) - int'(do_pop);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset   = 1'b0;
      issue   = 1'b0;
      commit  = 1'b0;
      longP   = '0;
      res_rdy = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      chk("rst_res_val", res_val, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_inflight", inflight, 0);
      chk("rst_issue_allow", issue_allow, 1);
      chk("rst_overflow", overflow, 0);
      chk("rst_seq_err", seq_err, 0);

      // single operation
      issue = 1'b1;
      tick();
      issue = 1'b0;
      chk("single_inflight1", inflight, 1);
      repeat (3) tick();
      commit = 1'b1;
      longP  = 64'h0000_0001_FFFF_FFFE;
      tick();
      commit = 1'b0;
      chk("single_inflight0", inflight, 0);
      chk("single_res_val", res_val, 1);
      chk("single_res_data", res_data, 64'h0000_0001_FFFF_FFFE);
      res_rdy = 1'b1;
      tick();
      res_rdy = 1'b0;
      chk("single_drained", res_val, 0);

      // fill under back-pressure
      for (int i = 0; i < 8; i++) begin
         if (i == 7) chk("fill_allow_before_8th", issue_allow, 1);
         issue = 1'b1;
         tick();
      end
      issue = 1'b0;
      chk("fill_allow_after_8th", issue_allow, 0);
      chk("fill_inflight8", inflight, 8);
      for (int i = 1; i <= 8; i++) begin
         commit = 1'b1;
         longP  = 64'(i);
         tick();
      end
      commit = 1'b0;
      chk("fill_occupancy", occupancy, 8);
      chk("fill_inflight0", inflight, 0);
      chk("fill_overflow", overflow, 0);
      chk("fill_head", res_data, 1);

      // push and pop together while full
      issue = 1'b1;
      tick();
      issue   = 1'b0;
      commit  = 1'b1;
      longP   = 64'd9;
      res_rdy = 1'b1;
      tick();
      commit  = 1'b0;
      res_rdy = 1'b0;
      chk("pp_occupancy", occupancy, 8);
      chk("pp_overflow", overflow, 0);
      chk("pp_head", res_data, 2);

      // commit while full with no pop is dropped
      issue = 1'b1;
      tick();
      issue  = 1'b0;
      commit = 1'b1;
      longP  = 64'hDEAD;
      tick();
      commit = 1'b0;
      chk("ovf_flag", overflow, 1);
      chk("ovf_occupancy", occupancy, 8);
      chk("ovf_seq_err", seq_err, 0);
      res_rdy = 1'b1;
      repeat (8) tick();
      res_rdy = 1'b0;
      chk("ovf_drained", res_val, 0);
      chk("ovf_sb_empty", sb.size(), 0);

      // second fill walks the pointers across the wrap
      for (int i = 0; i < 8; i++) begin
         issue = 1'b1;
         tick();
         issue  = 1'b0;
         commit = 1'b1;
         longP  = 64'hA5A5_0000_0000_0100 + 64'(i);
         tick();
         commit = 1'b0;
      end
      chk("wrap_occupancy", occupancy, 8);
      res_rdy = 1'b1;
      repeat (8) tick();
      res_rdy = 1'b0;
      chk("wrap_sb_empty", sb.size(), 0);
      chk("ovf_sticky", overflow, 1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("ovf_cleared", overflow, 0);

      // commit with nothing in flight
      commit = 1'b1;
      longP  = 64'h55;
      tick();
      commit = 1'b0;
      chk("seq_err_flag", seq_err, 1);
      chk("seq_err_occupancy", occupancy, 1);
      chk("seq_err_inflight", inflight, 0);
      res_rdy = 1'b1;
      tick();
      res_rdy = 1'b0;

      // in-flight counter saturates
      issue = 1'b1;
      repeat (9) tick();
      issue = 1'b0;
      chk("sat_inflight", inflight, 8);
      reset = 1'b0;
      tick();
      reset = 1'b1;

      // reset with 3 buffered and 2 in flight
      issue = 1'b1;
      repeat (5) tick();
      issue = 1'b0;
      for (int i = 0; i < 3; i++) begin
         commit = 1'b1;
         longP  = 64'h7700 + 64'(i);
         tick();
      end
      commit = 1'b0;
      chk("mid_occupancy", occupancy, 3);
      chk("mid_inflight", inflight, 2);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("mid_rst_occupancy", occupancy, 0);
      chk("mid_rst_inflight", inflight, 0);
      chk("mid_rst_res_val", res_val, 0);
      chk("mid_rst_res_data", res_data, 0);
      chk("mid_rst_issue_allow", issue_allow, 1);
      chk("mid_rst_seq_err", seq_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
